// File: rtl/cpu_pkg.sv
// ============================================================================
// Module      : cpu_pkg
// Description : Shared CPU definitions: flag vector type and bit positions.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

  typedef logic [3:0] flags_t;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

`default_nettype wire

// File: rtl/or_16bit.sv
// ============================================================================
// Module      : or_16bit
// Description : 16-bit OR reduction; high when any input bit is set.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module or_16bit (
  input  logic [15:0] din,
  output logic        any_set
);

  assign any_set = |din;

endmodule

`default_nettype wire

// File: rtl/alu_flag_reg.sv
// ============================================================================
// Module      : alu_flag_reg
// Description : Two-stage ALU flag pipeline; S1 captures slice partials, S2
//               reduces them and commits {N,Z,C,V}.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_flag_reg
  import cpu_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  input  logic             set_flags,
  input  logic [WIDTH-1:0] result,
  input  logic             carry_in,
  input  logic             ovf_in,
  input  logic             flush,
  output flags_t           flags,
  output logic             flags_busy,
  output logic             commit
);

  // WIDTH must be a multiple of 16 in the range 16..64.
  localparam int c_num_slices = WIDTH / 16;

  logic [c_num_slices-1:0] w_partial;
  logic                    w_load;
  logic                    w_s2_fire;
  flags_t                  w_s2_flags;

  logic                    r_s1_valid;
  logic [c_num_slices-1:0] r_s1_partial;
  logic                    r_s1_msb;
  logic                    r_s1_carry;
  logic                    r_s1_ovf;
  flags_t                  r_flags;
  logic                    r_commit;

  generate
    for (genvar gi = 0; gi < c_num_slices; gi++) begin : g_slice
      or_16bit u_or_16bit (
        .din     (result[gi*16 +: 16]),
        .any_set (w_partial[gi])
      );
    end
  endgenerate

  assign w_load    = in_valid & set_flags & ~flush;
  // Flush kills the op sitting in S1 as well as the one arriving now.
  assign w_s2_fire = r_s1_valid & ~flush;

  always_comb begin
    w_s2_flags         = '0;
    w_s2_flags[FLAG_N] = r_s1_msb;
    w_s2_flags[FLAG_Z] = ~(|r_s1_partial);
    w_s2_flags[FLAG_C] = r_s1_carry;
    w_s2_flags[FLAG_V] = r_s1_ovf;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1_valid   <= 1'b0;
      r_s1_partial <= '0;
      r_s1_msb     <= 1'b0;
      r_s1_carry   <= 1'b0;
      r_s1_ovf     <= 1'b0;
      r_flags      <= '0;
      r_commit     <= 1'b0;
    end else begin
      r_s1_valid <= w_load;
      if (w_load) begin
        r_s1_partial <= w_partial;
        r_s1_msb     <= result[WIDTH-1];
        r_s1_carry   <= carry_in;
        r_s1_ovf     <= ovf_in;
      end
      r_commit <= w_s2_fire;
      if (w_s2_fire) begin
        r_flags <= w_s2_flags;
      end
    end
  end

  assign flags      = r_flags;
  assign commit     = r_commit;
  assign flags_busy = r_s1_valid | w_load;

endmodule

`default_nettype wire

// File: tb/tb_alu_flag_reg.sv
// ============================================================================
// Module      : tb_alu_flag_reg
// Description : Directed self-checking bench for alu_flag_reg (WIDTH=64).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_flag_reg;

  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic        set_flags;
  logic [63:0] result;
  logic        carry_in;
  logic        ovf_in;
  logic        flush;
  logic [3:0]  flags;
  logic        flags_busy;
  logic        commit;

  int n_assert;
  int n_fail;

  alu_flag_reg #(.WIDTH(64)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .set_flags  (set_flags),
    .result     (result),
    .carry_in   (carry_in),
    .ovf_in     (ovf_in),
    .flush      (flush),
    .flags      (flags),
    .flags_busy (flags_busy),
    .commit     (commit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic s, input logic [63:0] res,
                       input logic c, input logic o, input logic f);
    in_valid  = v;
    set_flags = s;
    result    = res;
    carry_in  = c;
    ovf_in    = o;
    flush     = f;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    reset_n  = 1'b0;
    idle();

    // Reset state
    #3;
    check("rst_flags", flags, 4'b0000);
    check("rst_commit", commit, 1'b0);
    check("rst_busy", flags_busy, 1'b0);
    tick();
    reset_n = 1'b1;

    // Zero result with carry -> {N,Z,C,V} = 0110 two cycles later
    drive(1'b1, 1'b1, 64'h0, 1'b1, 1'b0, 1'b0);
    #1;
    check("zero_busy_t", flags_busy, 1'b1);
    tick();
    idle();
    #1;
    check("zero_busy_t1", flags_busy, 1'b1);
    check("zero_commit_t1", commit, 1'b0);
    check("zero_flags_t1", flags, 4'b0000);
    tick();
    check("zero_flags_t2", flags, 4'b0110);
    check("zero_commit_t2", commit, 1'b1);
    check("zero_busy_t2", flags_busy, 1'b0);
    tick();
    check("zero_commit_t3", commit, 1'b0);
    check("zero_hold_t3", flags, 4'b0110);

    // MSB only with overflow -> 1001
    drive(1'b1, 1'b1, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0);
    tick();
    idle();
    tick();
    check("msb_flags", flags, 4'b1001);
    check("msb_commit", commit, 1'b1);

    // Bit 0 only -> not zero
    drive(1'b1, 1'b1, 64'h1, 1'b0, 1'b0, 1'b0);
    tick();
    idle();
    tick();
    check("bit0_flags", flags, 4'b0000);

    // Zero again, then a lone bit in the second slice
    drive(1'b1, 1'b1, 64'h0, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 1'b1, 64'h0000_0000_0001_0000, 1'b0, 1'b0, 1'b0);
    tick();
    idle();
    check("z_slice_a", flags, 4'b0100);
    tick();
    check("bit16_flags", flags, 4'b0000);
    check("bit16_commit", commit, 1'b1);
    tick();

    // Back-to-back 0, 5, 0 -> Z = 1, 0, 1 on consecutive cycles
    drive(1'b1, 1'b1, 64'h0, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 1'b1, 64'h5, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 1'b1, 64'h0, 1'b0, 1'b0, 1'b0);
    check("b2b_flags0", flags, 4'b0100);
    check("b2b_commit0", commit, 1'b1);
    tick();
    idle();
    check("b2b_flags1", flags, 4'b0000);
    check("b2b_commit1", commit, 1'b1);
    tick();
    check("b2b_flags2", flags, 4'b0100);
    check("b2b_commit2", commit, 1'b1);
    tick();
    check("b2b_commit_end", commit, 1'b0);

    // Op then flush next cycle (with a same-cycle op that must be discarded)
    drive(1'b1, 1'b1, 64'h5, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 1'b1, 64'h0, 1'b1, 1'b1, 1'b1);
    #1;
    check("flush_busy_t1", flags_busy, 1'b1);
    tick();
    idle();
    #1;
    check("flush_commit_t2", commit, 1'b0);
    check("flush_flags_t2", flags, 4'b0100);
    check("flush_busy_t2", flags_busy, 1'b0);
    tick();
    check("flush_commit_t3", commit, 1'b0);
    check("flush_flags_t3", flags, 4'b0100);

    // in_valid without set_flags, and set_flags without in_valid
    drive(1'b1, 1'b0, 64'h5, 1'b1, 1'b1, 1'b0);
    #1;
    check("nosf_busy", flags_busy, 1'b0);
    tick();
    drive(1'b0, 1'b1, 64'h5, 1'b1, 1'b1, 1'b0);
    #1;
    check("noiv_busy", flags_busy, 1'b0);
    check("nosf_commit", commit, 1'b0);
    tick();
    idle();
    check("nosf_busy_s1", flags_busy, 1'b0);
    check("noiv_commit", commit, 1'b0);
    tick();
    check("noiv_flags", flags, 4'b0100);

    // Async reset mid-cycle while commit high and S1 valid
    drive(1'b1, 1'b1, 64'h5, 1'b1, 1'b1, 1'b0);
    tick();
    drive(1'b1, 1'b1, 64'h0, 1'b1, 1'b1, 1'b0);
    tick();
    idle();
    check("pre_rst_flags", flags, 4'b0011);
    check("pre_rst_commit", commit, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_flags", flags, 4'b0000);
    check("arst_commit", commit, 1'b0);
    check("arst_busy", flags_busy, 1'b0);
    tick();
    reset_n = 1'b1;
    tick();
    check("post_rst_commit0", commit, 1'b0);
    tick();
    check("post_rst_commit1", commit, 1'b0);
    check("post_rst_flags", flags, 4'b0000);

    // First commit after release comes from a fresh op
    drive(1'b1, 1'b1, 64'h0, 1'b0, 1'b0, 1'b0);
    tick();
    idle();
    tick();
    check("fresh_flags", flags, 4'b0100);
    check("fresh_commit", commit, 1'b1);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/alu_flag_reg.md
ALU_FLAG_REG -- requirements
Module: alu_flag_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 64, ALU datapath width; legal values are multiples of 16 from 16 to 64.
REQ-002 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port in_valid, input, 1, ALU result present this cycle.
REQ-005 SHALL have port set_flags, input, 1, qualifies in_valid; the op writes the flag register.
REQ-006 SHALL have port result, input, WIDTH, ALU result.
REQ-007 SHALL have port carry_in, input, 1, ALU carry-out.
REQ-008 SHALL have port ovf_in, input, 1, ALU overflow.
REQ-009 SHALL have port flush, input, 1, kills all in-flight ops.
REQ-010 SHALL have port flags, output, 4, committed {N,Z,C,V}, registered.
REQ-011 SHALL have port flags_busy, output, 1, a flag-setting op is in flight (branch logic stalls).
REQ-012 SHALL have port commit, output, 1, single-cycle pulse when flags updated.

Function
REQ-013 SHALL be a 2-stage pipeline: S1 captures op, S2 reduces and commits.
REQ-014 SHALL, at the edge ending cycle t with in_valid&set_flags, load S1: valid bit, WIDTH/16 partial zero-ORs (one per 16-bit slice), result MSB, carry_in, ovf_in.
REQ-015 SHALL ignore set_flags when in_valid=0, and ignore in_valid when set_flags=0 (S1 loads invalid).
REQ-016 SHALL, at the next edge, when S1 valid: Z = NOR of partials, N = stored MSB, C, V stored; write flags and assert commit for one cycle.
REQ-017 SHALL therefore give latency 2: input at cycle t, flags visible cycle t+2.
REQ-018 SHALL hold flags unchanged on every cycle without commit.
REQ-019 SHALL accept one op per cycle with no back-pressure; back-to-back ops commit on consecutive cycles in order.
REQ-020 SHALL drive flags_busy combinationally = S1 valid OR (in_valid & set_flags & ~flush).
REQ-021 SHALL, with flush=1, clear S1 valid and suppress the commit of the op currently in S1; same-cycle input is also discarded.
REQ-022 SHALL leave flags unchanged by flush.
REQ-023 SHALL compute Z=1 only when all WIDTH result bits are 0; a single 1 in any bit including bit 0 or bit WIDTH-1 gives Z=0.

Reset
REQ-024 SHALL, while reset_n=0, immediately force flags=4'b0000, commit=0, S1 valid=0, S1 data=0, independent of clk.
REQ-025 SHALL, on reset mid-operation, discard the in-flight op; the first commit after release is from an op accepted after release.
REQ-026 SHALL deassert reset synchronously to clk at the integration level; the block does not synchronise it.

Structure
REQ-027 SHALL place flag bit index constants (N=3, Z=2, C=1, V=0) and the flag vector typedef in shared package cpu_pkg.
REQ-028 SHALL instantiate the existing 16-bit OR reduction sub-module or_16bit once per slice for S1 partials; the final combine in S2 is gate-level.
REQ-029 SHALL contain no latches; all storage is edge-triggered with asynchronous clear.

Verification
REQ-030 SHALL cover: result=64'h0, carry=1, ovf=0, set_flags=1 at t -> flags=4'b0110, commit=1 at t+2.
REQ-031 SHALL cover: result=64'h8000_0000_0000_0000, ovf=1 -> flags=4'b1001 at t+2; result=64'h1 -> Z=0.
REQ-032 SHALL cover: three back-to-back ops with results 0, 5, 0 -> Z sequence 1,0,1 on cycles t+2..t+4, commit high three cycles.
REQ-033 SHALL cover: op at t, flush at t+1 -> no commit at t+2, flags keep prior value, flags_busy 0 at t+2.
REQ-034 SHALL cover: in_valid=1, set_flags=0 -> flags_busy=0, no commit, flags unchanged.
REQ-035 SHALL cover: reset_n low mid-cycle while S1 valid -> flags=0 and commit=0 before next clk edge; no commit after release.
